// File: rtl/guess_entry.sv
// Keypad front end: collects four BCD digits with backspace/clear/enter and offers the guess downstream.
// Define GUESS_DUP_CHECK_EN to refuse a digit already present in the current guess.
module guess_entry #(
    parameter int ATTEMPT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_valid,
    input  logic [3:0]           key_code,
    input  logic                 round_clear,
    output logic [15:0]          guess,
    output logic [2:0]           digit_count,
    output logic                 guess_valid,
    input  logic                 guess_ready,
    output logic                 key_reject,
    output logic [ATTEMPT_W-1:0] attempt
);

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_FULL    = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

    localparam logic [3:0] KEY_BKSP  = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;
    localparam logic [3:0] KEY_ENTER = 4'hC;

    state_t               state_q, state_d;
    logic [15:0]          guess_q, guess_d;
    logic [2:0]           count_q, count_d;
    logic                 valid_q, valid_d;
    logic                 reject_q, reject_d;
    logic [ATTEMPT_W-1:0] attempt_q, attempt_d;
    logic                 dup;
    logic                 is_digit;

    assign is_digit = (key_code <= 4'd9);

`ifdef GUESS_DUP_CHECK_EN
    // Only nibbles below count_q hold entered digits; the rest read 0xF and never match.
    logic [3:0] match;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_match
            assign match[gi] = (count_q > 3'(gi)) && (guess_q[15-4*gi -: 4] == key_code);
        end
    endgenerate
    assign dup = |match;
`else
    assign dup = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        guess_d   = guess_q;
        count_d   = count_q;
        valid_d   = valid_q;
        reject_d  = 1'b0;
        attempt_d = attempt_q;

        case (state_q)
            ST_ENTRY, ST_FULL: begin
                if (key_valid) begin
                    if (is_digit) begin
                        if (state_q == ST_FULL || dup) begin
                            reject_d = 1'b1;
                        end else begin
                            for (int k = 0; k < 4; k++) begin
                                if (count_q == 3'(k)) guess_d[15-4*k -: 4] = key_code;
                            end
                            count_d = count_q + 3'd1;
                            if (count_q == 3'd3) state_d = ST_FULL;
                        end
                    end else if (key_code == KEY_BKSP) begin
                        if (count_q == 3'd0) begin
                            reject_d = 1'b1;
                        end else begin
                            for (int k = 0; k < 4; k++) begin
                                if (count_q == 3'(k + 1)) guess_d[15-4*k -: 4] = 4'hF;
                            end
                            count_d = count_q - 3'd1;
                            state_d = ST_ENTRY;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        guess_d = 16'hFFFF;
                        count_d = 3'd0;
                        state_d = ST_ENTRY;
                    end else if (key_code == KEY_ENTER) begin
                        if (state_q == ST_FULL) begin
                            state_d = ST_PENDING;
                            valid_d = 1'b1;
                        end else begin
                            reject_d = 1'b1;
                        end
                    end
                end
            end
            ST_PENDING: begin
                // Keys are dropped silently while the guess waits for the scorer.
                if (guess_ready) begin
                    guess_d = 16'hFFFF;
                    count_d = 3'd0;
                    valid_d = 1'b0;
                    state_d = ST_ENTRY;
                    if (attempt_q != {ATTEMPT_W{1'b1}}) attempt_d = attempt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_ENTRY;
                guess_d = 16'hFFFF;
                count_d = 3'd0;
                valid_d = 1'b0;
            end
        endcase

        if (round_clear) begin
            state_d   = ST_ENTRY;
            guess_d   = 16'hFFFF;
            count_d   = 3'd0;
            valid_d   = 1'b0;
            reject_d  = 1'b0;
            attempt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ENTRY;
            guess_q   <= 16'hFFFF;
            count_q   <= 3'd0;
            valid_q   <= 1'b0;
            reject_q  <= 1'b0;
            attempt_q <= '0;
        end else begin
            state_q   <= state_d;
            guess_q   <= guess_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            reject_q  <= reject_d;
            attempt_q <= attempt_d;
        end
    end

    assign guess       = guess_q;
    assign digit_count = count_q;
    assign guess_valid = valid_q;
    assign key_reject  = reject_q;
    assign attempt     = attempt_q;

endmodule
